// File: rtl/branch_stats_counter.sv
// branch_stats_counter
//   Counts retired, taken and (optionally) mispredicted branches from the core
//   and publishes periodic stable snapshots for the seven-segment display path.
//   Optional feature macro: BRANCH_STATS_MISPRED_EN builds the mispredict
//   counter and its snapshot. When the macro is undefined, o_mispred is tied
//   to zero and no mispredict registers exist.
module branch_stats_counter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SNAP_PERIOD = 16,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_br_valid,
    input  logic             i_br_taken,
    input  logic             i_br_mispred,
    input  logic             i_clr,
    input  logic             i_freeze,
    output logic [CNT_W-1:0] o_branches,
    output logic [CNT_W-1:0] o_taken,
    output logic [CNT_W-1:0] o_mispred,
    output logic             o_snap_stb,
    output logic             o_frozen
);

    localparam int unsigned      TMR_W      = (SNAP_PERIOD > 2) ? $clog2(SNAP_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SNAP_PERIOD - 1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic             snap_now;
    logic             count_en;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] tk_cnt;
    logic [CNT_W-1:0] br_snap;
    logic [CNT_W-1:0] tk_snap;
    logic             snap_stb;

    // Increment with either saturation at all-ones or natural wrap to zero.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (SATURATE && (v == '1)) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Events are counted on any edge where the registered state is RUN, so
    // the event in the cycle that requests FROZEN is still taken.
    assign count_en = (state == ST_RUN) && i_br_valid;
    assign snap_now = (timer == '0);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: freeze is a level; clear never touches the state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (i_freeze)  state_nxt = ST_FROZEN;
            ST_FROZEN: if (!i_freeze) state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    assign o_frozen = (state == ST_FROZEN);

    // Live branch and taken counters; clear has priority over events.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else if (i_clr) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else begin
            if (count_en) begin
                br_cnt <= bump(br_cnt);
            end
            if (count_en && i_br_taken) begin
                tk_cnt <= bump(tk_cnt);
            end
        end
    end

    // Snapshot timer: free-running down-counter, reloaded at zero or on clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer <= TMR_RELOAD;
        end else if (i_clr || snap_now) begin
            timer <= TMR_RELOAD;
        end else begin
            timer <= timer - TMR_W'(1);
        end
    end

    // Snapshot registers and strobe; the copy takes the pre-update live values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_snap  <= '0;
            tk_snap  <= '0;
            snap_stb <= 1'b0;
        end else if (i_clr) begin
            br_snap  <= '0;
            tk_snap  <= '0;
            snap_stb <= 1'b0;
        end else if (snap_now) begin
            br_snap  <= br_cnt;
            tk_snap  <= tk_cnt;
            snap_stb <= 1'b1;
        end else begin
            snap_stb <= 1'b0;
        end
    end

    assign o_branches = br_snap;
    assign o_taken    = tk_snap;
    assign o_snap_stb = snap_stb;

`ifdef BRANCH_STATS_MISPRED_EN
    logic [CNT_W-1:0] mp_cnt;
    logic [CNT_W-1:0] mp_snap;

    // Live mispredict counter, same clear/freeze rules as the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mp_cnt <= '0;
        end else if (i_clr) begin
            mp_cnt <= '0;
        end else if (count_en && i_br_mispred) begin
            mp_cnt <= bump(mp_cnt);
        end
    end

    // Mispredict snapshot, copied alongside the other snapshots.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mp_snap <= '0;
        end else if (i_clr) begin
            mp_snap <= '0;
        end else if (snap_now) begin
            mp_snap <= mp_cnt;
        end
    end

    assign o_mispred = mp_snap;
`else
    logic unused_mispred;

    assign unused_mispred = i_br_mispred;
    assign o_mispred      = '0;
`endif

endmodule
